// File: rtl/microproc_ctrl_fsm.sv
// rtl/microproc_ctrl_fsm.sv - multi-cycle fetch/decode/execute control unit for the 12-bit datapath
//
// Optional feature macro: STEP_MODE_EN (adds STEP input and PAUSE state after each EXEC).
//
// Ports:
//   CLK, RESET (sync, active-low)  clock and reset
//   START                          leave IDLE when high
//   DATA_IN, MEM_ACK               memory read data / 1-cycle completion pulse
//   OVF                            datapath adder overflow
//   STEP                           (STEP_MODE_EN only) advance from PAUSE to FETCH
//   MEM_REQ, CTRL_ADDR             memory request and address select (0 = PC, 1 = OPERAND)
//   WE_A, WE_B, CTRL_A, CIN        register write strobes, A source select, adder carry-in
//   WE_PC, CTRL_PC                 PC write strobe and source select (0 = PC+1, 1 = OPERAND)
//   OPERAND                        zero-extended instruction operand
//   BUSY, HALTED, ILLEGAL, BUS_ERR status
module microproc_ctrl_fsm #(
    parameter int DATA_W      = 12,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              MEM_ACK,
    input  logic              OVF,
`ifdef STEP_MODE_EN
    input  logic              STEP,
`endif
    output logic              MEM_REQ,
    output logic              CTRL_ADDR,
    output logic              WE_A,
    output logic              WE_B,
    output logic              CTRL_A,
    output logic              CIN,
    output logic              WE_PC,
    output logic              CTRL_PC,
    output logic [DATA_W-1:0] OPERAND,
    output logic              BUSY,
    output logic              HALTED,
    output logic              ILLEGAL,
    output logic              BUS_ERR
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_LDB  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_JOV  = 4'h6;
    localparam logic [3:0] OP_HLT  = 4'hF;

`ifdef STEP_MODE_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT, S_PAUSE} state_t;
    localparam state_t AFTER_EXEC = S_PAUSE;
`else
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;
    localparam state_t AFTER_EXEC = S_FETCH;
`endif

    state_t             state, next_state;
    logic [DATA_W-1:0]  ir;
    logic               ovf_flag;
    logic [CNT_W-1:0]   wait_cnt;
    logic               bus_err_q;
    logic               load_ir, load_ovf, timeout;
    logic [3:0]         opcode;

    assign opcode  = ir[DATA_W-1:DATA_W-4];
    assign OPERAND = {4'b0000, ir[DATA_W-5:0]};
    assign BUS_ERR = bus_err_q;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= S_IDLE;
            ir        <= '0;
            ovf_flag  <= 1'b0;
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state <= next_state;
            if (load_ir)  ir        <= DATA_IN;
            if (load_ovf) ovf_flag  <= OVF;
            if (timeout)  bus_err_q <= 1'b1;
            // Counts cycles a request has gone unanswered; any ACK or idle bus restarts it,
            // which also covers the back-to-back LDx ACK -> FETCH request.
            if (MEM_REQ && !MEM_ACK) wait_cnt <= wait_cnt + 1'b1;
            else                     wait_cnt <= '0;
        end
    end

    always_comb begin
        next_state = state;
        MEM_REQ    = 1'b0;
        CTRL_ADDR  = 1'b0;
        WE_A       = 1'b0;
        WE_B       = 1'b0;
        CTRL_A     = 1'b0;
        CIN        = 1'b0;
        WE_PC      = 1'b0;
        CTRL_PC    = 1'b0;
        ILLEGAL    = 1'b0;
        load_ir    = 1'b0;
        load_ovf   = 1'b0;
        timeout    = 1'b0;
        BUSY       = (state != S_IDLE) && (state != S_HALT);
        HALTED     = (state == S_HALT);

        case (state)
            S_IDLE: if (START) next_state = S_FETCH;
            S_FETCH: begin
                MEM_REQ = 1'b1;
                if (MEM_ACK) begin
                    load_ir    = 1'b1;
                    WE_PC      = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                ILLEGAL    = (opcode > OP_JOV) && (opcode != OP_HLT);
                next_state = S_EXEC;
            end
            S_EXEC: begin
                next_state = AFTER_EXEC;
                case (opcode)
                    OP_LDA, OP_LDB: begin
                        MEM_REQ   = 1'b1;
                        CTRL_ADDR = 1'b1;
                        if (MEM_ACK) begin
                            WE_A = (opcode == OP_LDA);
                            WE_B = (opcode == OP_LDB);
                        end else begin
                            next_state = S_EXEC;
                        end
                    end
                    OP_ADD, OP_ADDI: begin
                        WE_A     = 1'b1;
                        CTRL_A   = 1'b1;
                        CIN      = (opcode == OP_ADDI);
                        load_ovf = 1'b1;
                    end
                    OP_JMP: begin
                        WE_PC   = 1'b1;
                        CTRL_PC = 1'b1;
                    end
                    OP_JOV: begin
                        WE_PC   = ovf_flag;
                        CTRL_PC = ovf_flag;
                    end
                    OP_HLT:  next_state = S_HALT;
                    default: ;
                endcase
            end
`ifdef STEP_MODE_EN
            S_PAUSE: if (STEP) next_state = S_FETCH;
`endif
            default: ;
        endcase

        // Last allowed waiting cycle passed without ACK: give up and halt.
        if (MEM_REQ && !MEM_ACK && (wait_cnt == CNT_W'(ACK_TIMEOUT - 1))) begin
            timeout    = 1'b1;
            next_state = S_HALT;
        end

        // A reset cycle must not let any strobe reach the datapath.
        if (!RESET) begin
            MEM_REQ  = 1'b0;
            WE_A     = 1'b0;
            WE_B     = 1'b0;
            WE_PC    = 1'b0;
            ILLEGAL  = 1'b0;
            load_ir  = 1'b0;
            load_ovf = 1'b0;
            timeout  = 1'b0;
        end
    end

endmodule
